tmr_voter_monitor: RTL and testbench

TMR_VOTER_MONITOR -- requirements
Module: tmr_voter_monitor

---
 rtl/tmr_pkg.sv | 21 ++
 rtl/tmr_instance_tracker.sv | 72 +++++++
 rtl/tmr_voter_monitor.sv | 151 +++++++++++++++
 tb/tb_tmr_voter_monitor.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR voter/monitor:
// tracker state encoding, register map and CONTROL bits.
package tmr_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULTY  = 2'd2
  } tmr_state_e;

  localparam logic [7:0] OFF_STATUS     = 8'h00;
  localparam logic [7:0] OFF_CNT1       = 8'h04;
  localparam logic [7:0] OFF_CNT2       = 8'h08;
  localparam logic [7:0] OFF_CNT3       = 8'h0C;
  localparam logic [7:0] OFF_CNT_TRIPLE = 8'h10;
  localparam logic [7:0] OFF_CONTROL    = 8'h14;

  localparam int CTL_CLR_CNT   = 0;
  localparam int CTL_CLR_FAULT = 1;

endpackage

// File: rtl/tmr_instance_tracker.sv
// Per-instance health tracker: OK/SUSPECT/FAULTY FSM with
// disagreement streak and a saturating disagreement counter.
module tmr_instance_tracker
  import tmr_pkg::*;
#(
  parameter int PERSIST = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disagree,
  input  logic             ack_clr,
  input  logic             ctl_clr,
  input  logic             cnt_clr,
  output tmr_state_e       state,
  output logic             enter_fault,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [8:0] PERSIST_W = 9'(PERSIST);
  localparam bit         DIRECT    = (PERSIST == 1);

  logic [7:0] streak;
  logic [8:0] streak_inc;

  assign streak_inc = {1'b0, streak} + 9'd1;

  always_comb begin
    enter_fault = 1'b0;
    if (disagree) begin
      if (state == ST_OK)
        enter_fault = DIRECT;
      else if (state == ST_SUSPECT)
        enter_fault = (streak_inc >= PERSIST_W);
    end
  end

  // Fault entry wins over any clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_OK;
      streak <= '0;
    end else if (enter_fault) begin
      state  <= ST_FAULTY;
      streak <= streak_inc[7:0];
    end else if (state == ST_FAULTY) begin
      if (ack_clr || ctl_clr) begin
        state  <= ST_OK;
        streak <= '0;
      end
    end else if (ctl_clr) begin
      state  <= ST_OK;
      streak <= '0;
    end else if (disagree) begin
      state  <= ST_SUSPECT;
      streak <= streak_inc[7:0];
    end else begin
      state  <= ST_OK;
      streak <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (cnt_clr)
      cnt <= '0;
    else if (disagree && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/tmr_voter_monitor.sv
// Triple-modular-redundancy voter with per-instance health
// monitoring, resync handshake and a small register window.
module tmr_voter_monitor
  import tmr_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter int          PERSIST  = 4,
  parameter int          CNT_W    = 16,
  parameter logic [19:0] ADDRBASE = 20'h3002_0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inst_1_i,
  input  logic [WIDTH-1:0] inst_2_i,
  input  logic [WIDTH-1:0] inst_3_i,
  output logic [WIDTH-1:0] voted_o,
  output logic [2:0]       fault_o,
  output logic             resync_req_o,
  input  logic             resync_ack_i,
  input  logic             valid_i,
  input  logic             wbs_we_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  output logic             ready_o,
  output logic [31:0]      rdata_o
);

  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] ins [3];
  logic [2:0]       dis;
  logic [2:0]       enter;
  logic [2:0]       suspect;
  tmr_state_e       st [3];
  logic [CNT_W-1:0] cnt [3];
  logic [CNT_W-1:0] tcnt;
  logic             sticky;
  logic             triple;
  logic             busy;
  logic             hit;
  logic             acc;
  logic             ctl_wr;
  logic             cnt_clr;
  logic             flt_clr;
  logic             ack_clr;
  logic [7:0]       off;
  logic [31:0]      rd;
  logic             unused;

  assign ins[0] = inst_1_i;
  assign ins[1] = inst_2_i;
  assign ins[2] = inst_3_i;

  assign maj = (inst_1_i & inst_2_i)
             | (inst_1_i & inst_3_i)
             | (inst_2_i & inst_3_i);

  assign triple = (|(inst_1_i ^ inst_2_i))
               && (|(inst_1_i ^ inst_3_i))
               && (|(inst_2_i ^ inst_3_i));

  assign off     = wbs_adr_i[7:0];
  assign hit     = valid_i && (wbs_adr_i[31:12] == ADDRBASE);
  assign acc     = hit && !busy;
  assign ctl_wr  = acc && wbs_we_i && (off == OFF_CONTROL)
                && wstrb_i[0];
  assign cnt_clr = ctl_wr && wdata_i[CTL_CLR_CNT];
  assign flt_clr = ctl_wr && wdata_i[CTL_CLR_FAULT];
  assign ack_clr = resync_ack_i && resync_req_o;

  assign unused = ^{wbs_adr_i[11:8], wdata_i[31:2],
                    wstrb_i[3:1]};

  for (genvar k = 0; k < 3; k++) begin : g_trk
    assign dis[k] = |(ins[k] ^ maj);

    tmr_instance_tracker #(
      .PERSIST (PERSIST),
      .CNT_W   (CNT_W)
    ) u_trk (
      .clk         (clk),
      .rst         (rst),
      .disagree    (dis[k]),
      .ack_clr     (ack_clr),
      .ctl_clr     (flt_clr),
      .cnt_clr     (cnt_clr),
      .state       (st[k]),
      .enter_fault (enter[k]),
      .cnt         (cnt[k])
    );

    assign fault_o[k] = (st[k] == ST_FAULTY);
    assign suspect[k] = (st[k] == ST_SUSPECT);
  end

  always_comb begin
    rd = '0;
    if (!wbs_we_i) begin
      unique case (1'b1)
        off == OFF_STATUS:
          rd = {24'd0, resync_req_o, sticky,
                suspect, fault_o};
        off == OFF_CNT1:       rd = 32'(cnt[0]);
        off == OFF_CNT2:       rd = 32'(cnt[1]);
        off == OFF_CNT3:       rd = 32'(cnt[2]);
        off == OFF_CNT_TRIPLE: rd = 32'(tcnt);
        default:               rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      voted_o      <= '0;
      resync_req_o <= 1'b0;
      tcnt         <= '0;
      sticky       <= 1'b0;
    end else begin
      voted_o      <= maj;
      // A new fault keeps the request alive over an ack/clear.
      resync_req_o <= (|enter)
                   || (resync_req_o && !ack_clr && !flt_clr);
      if (cnt_clr) begin
        tcnt   <= '0;
        sticky <= 1'b0;
      end else begin
        if (triple && (tcnt != '1))
          tcnt <= tcnt + 1'b1;
        if (triple)
          sticky <= 1'b1;
      end
    end
  end

  // One ready pulse per access; rearmed when valid_i drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      ready_o <= 1'b0;
      rdata_o <= '0;
    end else begin
      if (!valid_i)
        busy <= 1'b0;
      else if (hit)
        busy <= 1'b1;
      ready_o <= acc;
      rdata_o <= acc ? rd : '0;
    end
  end

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Scoreboard bench for tmr_voter_monitor: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_tmr_voter_monitor;

  localparam int          W    = 32;
  localparam int          P    = 4;
  localparam int          CW   = 4;
  localparam logic [19:0] BASE = 20'h3002_0;
  localparam int          CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_1_i, inst_2_i, inst_3_i;
  logic [31:0] voted_o;
  logic [2:0]  fault_o;
  logic        resync_req_o, resync_ack_i;
  logic        valid_i, wbs_we_i;
  logic [31:0] wbs_adr_i, wdata_i;
  logic [3:0]  wstrb_i;
  logic        ready_o;
  logic [31:0] rdata_o;

  tmr_voter_monitor #(
    .WIDTH    (W),
    .PERSIST  (P),
    .CNT_W    (CW),
    .ADDRBASE (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_1_i     (inst_1_i),
    .inst_2_i     (inst_2_i),
    .inst_3_i     (inst_3_i),
    .voted_o      (voted_o),
    .fault_o      (fault_o),
    .resync_req_o (resync_req_o),
    .resync_ack_i (resync_ack_i),
    .valid_i      (valid_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_adr_i    (wbs_adr_i),
    .wdata_i      (wdata_i),
    .wstrb_i      (wstrb_i),
    .ready_o      (ready_o),
    .rdata_o      (rdata_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] voted;
    logic [2:0]  fault;
    logic        req;
    logic        ready;
  } exp_t;

  exp_t        vq[$];
  logic [31:0] rq[$];
  exp_t        mon_e;

  int n_vec = 0;
  int n_bad = 0;

  // bus/control drive state used by cyc()
  logic        g_rst = 1'b1;
  logic        g_v = 1'b0, g_we = 1'b0, g_ack = 1'b0;
  logic [31:0] g_adr = '0, g_wd = '0;
  logic [3:0]  g_ws = '0;

  // behavioural model
  int streak[3];
  bit faulty[3];
  int cnt[3];
  int tcnt;
  bit sticky, req, busy;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [31:0] a, b, c);
    logic [31:0] m, rd;
    logic [31:0] ins[3];
    bit          dis[3];
    bit          tri_ev, hit, acc, c0, c1, ackv, newly;
    int          ones;
    exp_t        e;
    @(negedge clk);
    inst_1_i = a; inst_2_i = b; inst_3_i = c;
    valid_i = g_v; wbs_we_i = g_we; wbs_adr_i = g_adr;
    wdata_i = g_wd; wstrb_i = g_ws;
    resync_ack_i = g_ack; rst = g_rst;
    if (g_rst) begin
      for (int k = 0; k < 3; k++) begin
        streak[k] = 0; faulty[k] = 0; cnt[k] = 0;
      end
      tcnt = 0; sticky = 0; req = 0; busy = 0;
      e = '0;
      vq.push_back(e);
      return;
    end
    ins[0] = a; ins[1] = b; ins[2] = c;
    for (int i = 0; i < 32; i++) begin
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      m[i] = (ones >= 2);
    end
    for (int k = 0; k < 3; k++) dis[k] = (ins[k] != m);
    tri_ev = (a != b) && (a != c) && (b != c);
    hit = g_v && (g_adr[31:12] == BASE);
    acc = hit && !busy;
    if (acc) begin
      rd = '0;
      if (!g_we) begin
        case (g_adr[7:0])
          8'h00: begin
            for (int k = 0; k < 3; k++) begin
              rd[k]     = faulty[k];
              rd[3 + k] = !faulty[k] && (streak[k] > 0);
            end
            rd[6] = sticky;
            rd[7] = req;
          end
          8'h04: rd = cnt[0];
          8'h08: rd = cnt[1];
          8'h0C: rd = cnt[2];
          8'h10: rd = tcnt;
          default: rd = '0;
        endcase
      end
      rq.push_back(rd);
    end
    c0 = acc && g_we && (g_adr[7:0] == 8'h14) && g_ws[0]
      && g_wd[0];
    c1 = acc && g_we && (g_adr[7:0] == 8'h14) && g_ws[0]
      && g_wd[1];
    ackv = g_ack && req;
    newly = 0;
    for (int k = 0; k < 3; k++) begin
      if (faulty[k]) begin
        if (ackv || c1) begin
          faulty[k] = 0; streak[k] = 0;
        end
      end else if (dis[k] && (streak[k] + 1 >= P)) begin
        faulty[k] = 1; streak[k]++; newly = 1;
      end else if (c1) streak[k] = 0;
      else if (dis[k]) streak[k]++;
      else streak[k] = 0;
      if (c0) cnt[k] = 0;
      else if (dis[k] && cnt[k] < CMAX) cnt[k]++;
    end
    if (c0) begin
      tcnt = 0; sticky = 0;
    end else if (tri_ev) begin
      if (tcnt < CMAX) tcnt++;
      sticky = 1;
    end
    req = newly || (req && !ackv && !c1);
    if (!g_v) busy = 0;
    else if (hit) busy = 1;
    e.voted = m;
    e.fault = {faulty[2], faulty[1], faulty[0]};
    e.req   = req;
    e.ready = acc;
    vq.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (vq.size() > 0) begin
      mon_e = vq.pop_front();
      chk("voted", voted_o, mon_e.voted);
      chk("fault", 32'(fault_o), 32'(mon_e.fault));
      chk("resync_req", 32'(resync_req_o), 32'(mon_e.req));
      chk("ready", 32'(ready_o), 32'(mon_e.ready));
      if (ready_o) begin
        if (rq.size() == 0)
          chk("ready_spurious", 32'(ready_o), 32'd0);
        else
          chk("rdata", rdata_o, rq.pop_front());
      end else begin
        chk("rdata_idle", rdata_o, 32'd0);
      end
    end
  end

  task automatic same(input logic [31:0] d, input int n);
    repeat (n) cyc(d, d, d);
  endtask

  task automatic bus_rd(input logic [11:0] off,
                        input logic [31:0] a, b, c);
    g_v = 1; g_we = 0; g_adr = {BASE, off};
    cyc(a, b, c);
    g_v = 0;
    cyc(a, b, c);
  endtask

  task automatic bus_wr(input logic [11:0] off,
                        input logic [31:0] val,
                        input logic [31:0] d);
    g_v = 1; g_we = 1; g_adr = {BASE, off};
    g_wd = val; g_ws = 4'hF;
    cyc(d, d, d);
    g_v = 0; g_we = 0;
    cyc(d, d, d);
  endtask

  logic [31:0] d, x, y;
  int          hold;
  int          sel;

  initial begin
    localparam logic [31:0] A5 = 32'hA5A5_A5A5;
    localparam logic [31:0] K5 = 32'h5A5A_5A5A;
    g_rst = 1;
    same(0, 3);
    g_rst = 0;

    // inst_3 disagreeing: CNT3 grows by one per cycle
    repeat (4) cyc(A5, A5, K5);
    bus_rd(12'h00C, A5, A5, K5);
    same(A5, 2);
    bus_wr(12'h014, 32'h1, A5);

    // inst_2 glitch shorter than PERSIST, then long enough
    d = 32'h1234_5678;
    repeat (3) cyc(d, d ^ 32'h1, d);
    bus_rd(12'h000, d, d, d);
    same(d, 2);
    repeat (4) cyc(d, d ^ 32'h100, d);
    same(d, 2);
    bus_rd(12'h000, d, d, d);

    // ack clears; ack coinciding with a new fault
    g_ack = 1; cyc(d, d, d); g_ack = 0;
    same(d, 2);
    repeat (4) cyc(d, d ^ 32'h8, d);
    same(d, 1);
    repeat (3) cyc(d, d, d ^ 32'h40);
    g_ack = 1; cyc(d, d, d ^ 32'h40); g_ack = 0;
    same(d, 2);
    g_ack = 1; cyc(d, d, d); g_ack = 0;
    same(d, 1);

    // triple-disagree and counter clear
    repeat (5) cyc(32'h1, 32'h2, 32'h4);
    bus_rd(12'h000, 0, 0, 0);
    bus_rd(12'h010, 0, 0, 0);
    bus_wr(12'h014, 32'h1, 0);
    bus_rd(12'h010, 0, 0, 0);
    bus_rd(12'h000, 0, 0, 0);
    bus_wr(12'h014, 32'h2, 0);
    bus_rd(12'h000, 0, 0, 0);

    // saturation, unmapped/readonly/control offsets
    repeat (20) cyc(d, d, ~d);
    bus_rd(12'h00C, d, d, d);
    bus_rd(12'h040, d, d, d);
    bus_rd(12'h014, d, d, d);
    bus_wr(12'h004, 32'hFFFF_FFFF, d);
    bus_rd(12'h00C, d, d, d);
    g_v = 1; g_adr = 32'h1000_0000;
    cyc(d, d, d);
    g_v = 0;

    // valid held: exactly one ready pulse
    g_v = 1; g_we = 0; g_adr = {BASE, 12'h000};
    same(d, 4);
    g_v = 0;
    same(d, 1);

    // reset coincident with a hit aborts the access
    g_v = 1; g_rst = 1;
    cyc(d, d, d);
    g_v = 0; g_rst = 0;
    same(d, 3);

    // randomized traffic
    hold = 0;
    for (int it = 0; it < 3000; it++) begin
      d = $urandom;
      x = $urandom | 32'h1;
      y = $urandom | 32'h2;
      sel = $urandom_range(0, 9);
      g_ack = ($urandom_range(0, 9) == 0);
      g_rst = ($urandom_range(0, 499) == 0);
      if (hold > 0) begin
        hold--;
        if (hold == 0) g_v = 0;
      end else if ($urandom_range(0, 5) == 0) begin
        g_v = 1;
        hold = $urandom_range(1, 3);
        g_we = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 6))
          0: g_adr = {BASE, 12'h000};
          1: g_adr = {BASE, 12'h004};
          2: g_adr = {BASE, 12'h008};
          3: g_adr = {BASE, 12'h00C};
          4: g_adr = {BASE, 12'h010};
          5: g_adr = {BASE, 12'h014};
          default: g_adr = {BASE, 12'h040};
        endcase
        if ($urandom_range(0, 9) == 0) g_adr[31:12] = ~BASE;
        g_wd = $urandom_range(0, 3);
        g_ws = 4'($urandom);
      end
      if (sel <= 5) cyc(d, d, d);
      else if (sel == 6) cyc(d ^ x, d, d);
      else if (sel == 7) cyc(d, d ^ x, d);
      else if (sel == 8) cyc(d, d, d ^ x);
      else cyc(d, d ^ x, d ^ y);
    end

    g_v = 0; g_ack = 0; g_rst = 0;
    same(0, 4);
    @(posedge clk);
    #2;
    chk("rq_drain", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
